// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle between three masters, the arbiter and one slave port.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface wb_rr_arbiter_if;
  logic [2:0]  m_cyc_i;
  logic [2:0]  m_stb_i;
  logic [2:0]  m_we_i;
  logic [95:0] m_adr_i;
  logic [95:0] m_dat_i;
  logic [11:0] m_sel_i;
  logic [31:0] m_dat_o;
  logic [2:0]  m_ack_o;
  logic [2:0]  m_err_o;
  logic [2:0]  m_rty_o;
  logic        s_cyc_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic [31:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic        s_err_i;
  logic        s_rty_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Three-master round-robin Wishbone arbiter; a grant lasts for the owner's whole cyc,
// and a slave that stalls a strobe for `timeout` cycles is aborted with err.
module wb_rr_arbiter #(
  parameter int tmo_width = 8,
  parameter int timeout   = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  wb_rr_arbiter_if.slave   bus,
  output logic [1:0]       grant_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  localparam bit                   TMO_EN  = (timeout != 0);
  localparam logic [tmo_width-1:0] TC_LAST = tmo_width'(timeout - 1);

  state_t               state_r;
  logic [1:0]           g_r;
  logic [tmo_width-1:0] tc_r;

  logic        cyc_g_s;
  logic        stb_g_s;
  logic        we_g_s;
  logic [31:0] adr_g_s;
  logic [31:0] dat_g_s;
  logic [3:0]  sel_g_s;
  logic [2:0]  onehot_s;
  logic        stall_s;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    case (i)
      2'd0:    inc3 = 2'd1;
      2'd1:    inc3 = 2'd2;
      default: inc3 = 2'd0;
    endcase
  endfunction

  // Search order g+1, g+2, g: the previous owner has lowest priority.
  function automatic logic [1:0] pick(input logic [1:0] g, input logic [2:0] req);
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] c3;
    c1 = inc3(g);
    c2 = inc3(c1);
    c3 = inc3(c2);
    if (req[c1])      pick = c1;
    else if (req[c2]) pick = c2;
    else              pick = c3;
  endfunction

  // Select the fields of the currently granted master.
  always_comb begin
    cyc_g_s  = 1'b0;
    stb_g_s  = 1'b0;
    we_g_s   = 1'b0;
    adr_g_s  = 32'h0000_0000;
    dat_g_s  = 32'h0000_0000;
    sel_g_s  = 4'h0;
    onehot_s = 3'b000;
    case (g_r)
      2'd0: begin
        cyc_g_s = bus.m_cyc_i[0]; stb_g_s = bus.m_stb_i[0]; we_g_s = bus.m_we_i[0];
        adr_g_s = bus.m_adr_i[31:0]; dat_g_s = bus.m_dat_i[31:0]; sel_g_s = bus.m_sel_i[3:0];
        onehot_s = 3'b001;
      end
      2'd1: begin
        cyc_g_s = bus.m_cyc_i[1]; stb_g_s = bus.m_stb_i[1]; we_g_s = bus.m_we_i[1];
        adr_g_s = bus.m_adr_i[63:32]; dat_g_s = bus.m_dat_i[63:32]; sel_g_s = bus.m_sel_i[7:4];
        onehot_s = 3'b010;
      end
      2'd2: begin
        cyc_g_s = bus.m_cyc_i[2]; stb_g_s = bus.m_stb_i[2]; we_g_s = bus.m_we_i[2];
        adr_g_s = bus.m_adr_i[95:64]; dat_g_s = bus.m_dat_i[95:64]; sel_g_s = bus.m_sel_i[11:8];
        onehot_s = 3'b100;
      end
      default: begin
        onehot_s = 3'b000;
      end
    endcase
  end

  assign stall_s = (state_r == ST_GRANT) && stb_g_s &&
                   !bus.s_ack_i && !bus.s_err_i && !bus.s_rty_i;

  // Bus routing: straight-through in GRANT, forced err pulse in TIMEOUT, quiet otherwise.
  always_comb begin
    bus.m_dat_o = bus.s_dat_i;
    bus.m_ack_o = 3'b000;
    bus.m_err_o = 3'b000;
    bus.m_rty_o = 3'b000;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = 32'h0000_0000;
    bus.s_dat_o = 32'h0000_0000;
    bus.s_sel_o = 4'h0;
    case (state_r)
      ST_GRANT: begin
        bus.s_cyc_o = cyc_g_s;
        bus.s_stb_o = stb_g_s;
        bus.s_we_o  = we_g_s;
        bus.s_adr_o = adr_g_s;
        bus.s_dat_o = dat_g_s;
        bus.s_sel_o = sel_g_s;
        bus.m_ack_o = {3{bus.s_ack_i}} & onehot_s;
        bus.m_err_o = {3{bus.s_err_i}} & onehot_s;
        bus.m_rty_o = {3{bus.s_rty_i}} & onehot_s;
      end
      ST_TIMEOUT: begin
        bus.m_err_o = onehot_s;
      end
      default: begin
        bus.m_err_o = 3'b000;
      end
    endcase
  end

  // Arbitration FSM with stall watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      g_r     <= 2'd2;
      tc_r    <= {tmo_width{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          tc_r <= {tmo_width{1'b0}};
          if (|bus.m_cyc_i) begin
            g_r     <= pick(g_r, bus.m_cyc_i);
            state_r <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!cyc_g_s) begin
            state_r <= ST_IDLE;
            tc_r    <= {tmo_width{1'b0}};
          end else if (stall_s) begin
            if (TMO_EN && (tc_r == TC_LAST)) begin
              state_r <= ST_TIMEOUT;
              tc_r    <= {tmo_width{1'b0}};
            end else begin
              tc_r <= tc_r + 1'b1;
            end
          end else begin
            tc_r <= {tmo_width{1'b0}};
          end
        end
        ST_TIMEOUT: begin
          tc_r    <= {tmo_width{1'b0}};
          state_r <= cyc_g_s ? ST_GRANT : ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          tc_r    <= {tmo_width{1'b0}};
        end
      endcase
    end
  end

  assign busy_o  = (state_r != ST_IDLE);
  assign grant_o = g_r;

endmodule
